// File: rtl/traffic_phase_arbiter_pkg.sv
// Shared light codes, direction codes and scheduler states for the intersection arbiter.
// Latency: n/a (definitions only); backpressure: n/a.
package traffic_pkg;

  localparam logic [2:0] LIGHT_RED = 3'b100;
  localparam logic [2:0] LIGHT_YEL = 3'b010;
  localparam logic [2:0] LIGHT_GRN = 3'b001;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_S = 2'd1;
  localparam logic [1:0] DIR_E = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GREEN   = 2'd1,
    ST_YELLOW  = 2'd2,
    ST_ALL_RED = 2'd3
  } state_t;

  // Approaches other than the current phase are always red.
  function automatic logic [2:0] light_code(input logic [1:0] dir,
                                            input logic [1:0] phase,
                                            input state_t     st);
    if (dir != phase) return LIGHT_RED;
    case (st)
      ST_GREEN:  return LIGHT_GRN;
      ST_YELLOW: return LIGHT_YEL;
      default:   return LIGHT_RED;
    endcase
  endfunction

endpackage

// File: rtl/traffic_phase_arbiter_if.sv
// Request and light bus between the detector/preempt side and the phase arbiter.
// Latency: n/a (wiring only); backpressure: none, all signals are levels.
interface traffic_phase_arbiter_if;

  logic [3:0] req;
  logic       emg_req;
  logic [1:0] emg_dir;
  logic [2:0] n_lights;
  logic [2:0] s_lights;
  logic [2:0] e_lights;
  logic [2:0] w_lights;
  logic [1:0] phase;
  logic       grant_vld;

  modport master (
    output req, emg_req, emg_dir,
    input  n_lights, s_lights, e_lights, w_lights, phase, grant_vld
  );

  modport slave (
    input  req, emg_req, emg_dir,
    output n_lights, s_lights, e_lights, w_lights, phase, grant_vld
  );

endinterface

// File: rtl/traffic_phase_arbiter_picker.sv
// Round-robin pick of the first requesting approach after the last-served one, with wrap.
// Latency: combinational; backpressure: none.
module traffic_rr_picker (
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] pick,
  output logic       any
);

  always_comb begin
    pick = last + 2'd1;
    any  = |req;
    // Walk offsets from farthest to nearest so the nearest requester wins.
    for (int i = 4; i >= 1; i--) begin
      if (req[2'(last + 2'(i))]) pick = 2'(last + 2'(i));
    end
  end

endmodule

// File: rtl/traffic_phase_arbiter.sv
// Demand-driven 4-way signal scheduler: round-robin green with min/max green, yellow, all-red, preemption.
// Latency: all outputs registered, lights follow the state on the same edge; backpressure: none.
module traffic_phase_arbiter
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W       = 8,
  parameter int unsigned GREEN_MIN   = 4,
  parameter int unsigned GREEN_MAX   = 16,
  parameter int unsigned YELLOW_TIME = 2,
  parameter int unsigned ALLRED_TIME = 1
) (
  input  logic                    clk,
  input  logic                    rst_a,
  traffic_phase_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
  localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
  localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_TIME - 1);
  localparam logic [CNT_W-1:0] ARED_LAST = CNT_W'(ALLRED_TIME - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  state_t           state_q;
  state_t           state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       phase_q;
  logic [1:0]       phase_d;
  logic [1:0]       rr_pick;
  logic             rr_any;
  logic [1:0]       target;
  logic             demand;
  logic             others;
  logic [2:0]       n_lights_q;
  logic [2:0]       s_lights_q;
  logic [2:0]       e_lights_q;
  logic [2:0]       w_lights_q;
  logic             grant_vld_q;

  traffic_rr_picker u_picker (
    .req  (bus.req),
    .last (phase_q),
    .pick (rr_pick),
    .any  (rr_any)
  );

  assign target = bus.emg_req ? bus.emg_dir : rr_pick;
  assign demand = bus.emg_req | rr_any;
  assign others = |(bus.req & ~(4'b0001 << phase_q));

  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    case (state_q)
      ST_IDLE: begin
        if (demand) begin
          state_d = ST_GREEN;
          phase_d = target;
        end
      end
      ST_GREEN: begin
        if (bus.emg_req) begin
          if (bus.emg_dir != phase_q) state_d = ST_YELLOW;
        end else if (cnt_q >= GMAX_LAST) begin
          // >= rather than == so a green stretched by preemption still ends once released.
          state_d = ST_YELLOW;
        end else if (cnt_q >= GMIN_LAST && (!bus.req[phase_q] || others)) begin
          state_d = ST_YELLOW;
        end
      end
      ST_YELLOW: begin
        if (cnt_q >= YEL_LAST) state_d = ST_ALL_RED;
      end
      ST_ALL_RED: begin
        if (cnt_q >= ARED_LAST) begin
          if (demand) begin
            state_d = ST_GREEN;
            phase_d = target;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      state_q <= ST_IDLE;
      phase_q <= DIR_W;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
    end
  end

  // Counter restarts on every state entry and saturates instead of wrapping.
  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      cnt_q <= '0;
    end else if (state_d != state_q) begin
      cnt_q <= '0;
    end else if (state_q != ST_IDLE && cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_a) begin
    if (!rst_a) begin
      n_lights_q  <= LIGHT_RED;
      s_lights_q  <= LIGHT_RED;
      e_lights_q  <= LIGHT_RED;
      w_lights_q  <= LIGHT_RED;
      grant_vld_q <= 1'b0;
    end else begin
      n_lights_q  <= light_code(DIR_N, phase_d, state_d);
      s_lights_q  <= light_code(DIR_S, phase_d, state_d);
      e_lights_q  <= light_code(DIR_E, phase_d, state_d);
      w_lights_q  <= light_code(DIR_W, phase_d, state_d);
      grant_vld_q <= (state_d == ST_GREEN);
    end
  end

  assign bus.n_lights  = n_lights_q;
  assign bus.s_lights  = s_lights_q;
  assign bus.e_lights  = e_lights_q;
  assign bus.w_lights  = w_lights_q;
  assign bus.phase     = phase_q;
  assign bus.grant_vld = grant_vld_q;

  a_one_open: assert property (@(posedge clk) disable iff (!rst_a)
    ((n_lights_q != LIGHT_RED) + (s_lights_q != LIGHT_RED) +
     (e_lights_q != LIGHT_RED) + (w_lights_q != LIGHT_RED)) <= 32'd1);

endmodule
